// File: rtl/parallel_lfsr_pkg.sv
// Shared types and helpers for the parallel LFSR pattern generator.
//   - gen_state_e : generator control states (IDLE, PRIME, RUN)
//   - chk_state_e : receive-checker states (SYNC, LOCK)
//   - lfsr_advance: runs n single-bit Fibonacci steps on a w-bit state and
//                   returns both the advanced state and the n emitted bits
//                   (first emitted bit in word[n-1]).
//   - CHK_MISS_LIMIT: consecutive mismatching words that drop checker lock.
package parallel_lfsr_pkg;

  // Widest LFSR the helper can advance; callers zero-extend into this width.
  localparam int LFSR_MAX_W     = 64;
  localparam int LFSR_IDX_W     = $clog2(LFSR_MAX_W);
  localparam int CHK_MISS_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } gen_state_e;

  typedef enum logic {
    SYNC,
    LOCK
  } chk_state_e;

  typedef struct packed {
    logic [LFSR_MAX_W-1:0] state;
    logic [LFSR_MAX_W-1:0] word;
  } lfsr_adv_t;

  // Bits of state above w-1 may pick up stale values while shifting; they
  // never reach the output bit or the feedback because poly is zero there,
  // and callers only keep state[w-1:0].
  function automatic lfsr_adv_t lfsr_advance(input logic [LFSR_MAX_W-1:0] state,
                                             input logic [LFSR_MAX_W-1:0] poly,
                                             input int                    n,
                                             input int                    w);
    lfsr_adv_t r;
    logic      fb;
    logic      ob;
    r.state = state;
    r.word  = '0;
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if (i < n) begin
        ob      = r.state[LFSR_IDX_W'(w - 1)];
        fb      = ^(r.state & poly);
        r.state = {r.state[LFSR_MAX_W-2:0], fb};
        r.word  = {r.word[LFSR_MAX_W-2:0], ob};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/parallel_lfsr_gen_chk.sv
// Self-synchronising PRBS checker for the parallel LFSR stream.
// SYNC absorbs received words into a window of the last LFSR_W bits; once
// enough words have arrived the window is exactly the generator state that
// produced them, and LOCK predicts each following word from it.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   chk_valid    : chk_data carries a received word this cycle
//   chk_data     : received word, MSB = oldest bit
//   chk_locked   : checker is predicting (LOCK)
//   chk_err_cnt  : mismatching words seen while locked, saturating
module parallel_lfsr_chk
  import parallel_lfsr_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter int                OUT_W  = 4,
  parameter logic [LFSR_W-1:0] POLY   = 16'hB400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_valid,
  input  logic [OUT_W-1:0] chk_data,
  output logic             chk_locked,
  output logic [15:0]      chk_err_cnt
);

  localparam int SYNC_WORDS = (LFSR_W + OUT_W - 1) / OUT_W;
  localparam int SC_W       = $clog2(SYNC_WORDS + 1);
  localparam int MC_W       = $clog2(CHK_MISS_LIMIT);

  chk_state_e              fsm_q, fsm_d;
  logic [LFSR_W-1:0]       win_q, win_d;
  logic [SC_W-1:0]         sync_q, sync_d;
  logic [MC_W-1:0]         miss_q, miss_d;
  logic [15:0]             err_q, err_d;
  lfsr_adv_t               adv;
  logic [LFSR_W-1:0]       pred_win;
  logic [LFSR_W+OUT_W-1:0] shift_cat;
  logic                    unused_adv;

  // The window holds the state that produced the oldest bit it contains, so
  // advancing it by OUT_W steps leaves the predicted word in its low bits.
  always_comb adv = lfsr_advance(LFSR_MAX_W'(win_q), LFSR_MAX_W'(POLY), OUT_W, LFSR_W);
  assign pred_win   = adv.state[LFSR_W-1:0];
  assign shift_cat  = {win_q, chk_data};
  assign unused_adv = ^adv;

  always_comb begin
    fsm_d  = fsm_q;
    win_d  = win_q;
    sync_d = sync_q;
    miss_d = miss_q;
    err_d  = err_q;
    if (chk_valid) begin
      case (fsm_q)
        SYNC: begin
          win_d = shift_cat[LFSR_W-1:0];
          if (sync_q == SC_W'(SYNC_WORDS - 1)) begin
            fsm_d  = LOCK;
            sync_d = '0;
            miss_d = '0;
          end else begin
            sync_d = sync_q + 1'b1;
          end
        end
        LOCK: begin
          // Keep running on the prediction so isolated bit errors do not
          // corrupt the local state.
          win_d = pred_win;
          if (pred_win[OUT_W-1:0] != chk_data) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (miss_q == MC_W'(CHK_MISS_LIMIT - 1)) begin
              fsm_d  = SYNC;
              miss_d = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: fsm_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= SYNC;
      win_q  <= '0;
      sync_q <= '0;
      miss_q <= '0;
      err_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      win_q  <= win_d;
      sync_q <= sync_d;
      miss_q <= miss_d;
      err_q  <= err_d;
    end
  end

  assign chk_locked  = (fsm_q == LOCK);
  assign chk_err_cnt = err_q;

endmodule

// File: rtl/parallel_lfsr_gen.sv
// Parallel Fibonacci LFSR pattern generator on a valid/ready stream.
// Each accepted transfer carries OUT_W PRBS bits (MSB = oldest bit). The
// word is precomputed one cycle ahead (PRIME) so RUN can hand out one word
// per cycle back-to-back.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   enable     : run request
//   seed_load  : one-cycle pulse, load seed_in (all-zero seed -> SEED)
//   seed_in    : runtime seed
//   out_valid, out_ready, out_data : output stream
//   xfer_cnt   : accepted transfers, wraps
//   seed_zero  : sticky, an all-zero seed was replaced with SEED
// Optional: define PARALLEL_LFSR_CHK_EN to add a receive checker with ports
//   chk_valid, chk_data (in) and chk_locked, chk_err_cnt (out).
module parallel_lfsr_gen
  import parallel_lfsr_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter int                OUT_W  = 4,
  parameter logic [LFSR_W-1:0] POLY   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              seed_zero
`ifdef PARALLEL_LFSR_CHK_EN
  ,
  input  logic              chk_valid,
  input  logic [OUT_W-1:0]  chk_data,
  output logic              chk_locked,
  output logic [15:0]       chk_err_cnt
`endif
);

  gen_state_e        fsm_q, fsm_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  data_p0, data_d;
  logic              vld_p0, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              zero_q, zero_d;
  lfsr_adv_t         adv;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [OUT_W-1:0]  word_adv;
  logic              hs;
  logic              unused_adv;

  always_comb adv = lfsr_advance(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(POLY), OUT_W, LFSR_W);
  assign lfsr_adv   = adv.state[LFSR_W-1:0];
  assign word_adv   = adv.word[OUT_W-1:0];
  assign unused_adv = ^adv;
  assign hs         = vld_p0 & out_ready;

  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    data_d = data_p0;
    vld_d  = vld_p0;
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (seed_load) begin
      // Reseed wins over everything: a pending word is dropped and a
      // coincident handshake is not counted.
      if (seed_in == '0) begin
        lfsr_d = SEED;
        zero_d = 1'b1;
      end else begin
        lfsr_d = seed_in;
      end
      vld_d = 1'b0;
      fsm_d = enable ? PRIME : IDLE;
    end else begin
      if (hs) cnt_d = cnt_q + 1'b1;
      case (fsm_q)
        IDLE: begin
          vld_d = 1'b0;
          if (enable) fsm_d = PRIME;
        end
        PRIME: begin
          data_d = word_adv;
          lfsr_d = lfsr_adv;
          vld_d  = 1'b1;
          fsm_d  = RUN;
        end
        RUN: begin
          // Without a handshake the word and valid hold, even if enable
          // drops. On stop the advanced state is kept for a seamless resume.
          if (hs) begin
            if (enable) begin
              data_d = word_adv;
              lfsr_d = lfsr_adv;
            end else begin
              vld_d = 1'b0;
              fsm_d = IDLE;
            end
          end
        end
        default: begin
          vld_d = 1'b0;
          fsm_d = IDLE;
        end
      endcase
    end
  end

  // Output stage register
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      lfsr_q  <= SEED;
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      data_p0 <= data_d;
      vld_p0  <= vld_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign xfer_cnt  = cnt_q;
  assign seed_zero = zero_q;

`ifdef PARALLEL_LFSR_CHK_EN
  parallel_lfsr_chk #(
    .LFSR_W (LFSR_W),
    .OUT_W  (OUT_W),
    .POLY   (POLY)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .chk_valid   (chk_valid),
    .chk_data    (chk_data),
    .chk_locked  (chk_locked),
    .chk_err_cnt (chk_err_cnt)
  );
`endif

endmodule

// File: tb/tb_parallel_lfsr_gen.sv
// Bench for parallel_lfsr_gen: directed cycle table on a 4-bit instance,
// randomized traffic against a bit-stream model, and a full-period run on a
// 16-bit, 1-bit-per-word instance.
module tb_parallel_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 4-bit instance
  logic        rst, en, rdy, ld;
  logic [3:0]  seed;
  logic        vld;
  logic [3:0]  dat;
  logic [31:0] cnt;
  logic        zflag;

  // 16-bit instance, one bit per word
  logic        rst16, en16, rdy16, ld16;
  logic [15:0] seed16;
  logic        vld16;
  logic        dat16;
  logic [31:0] cnt16;
  logic        z16;

`ifdef PARALLEL_LFSR_CHK_EN
  logic [3:0]  flip;
  logic        chk_v;
  logic        locked;
  logic [15:0] errc;
  logic        lk16;
  logic [15:0] ec16;
  assign chk_v = vld & rdy;
`endif

  parallel_lfsr_gen #(
    .LFSR_W(4), .OUT_W(4), .POLY(4'hC), .SEED(4'h1), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(rst), .enable(en), .seed_load(ld), .seed_in(seed),
    .out_valid(vld), .out_ready(rdy), .out_data(dat), .xfer_cnt(cnt),
    .seed_zero(zflag)
`ifdef PARALLEL_LFSR_CHK_EN
    , .chk_valid(chk_v), .chk_data(dat ^ flip), .chk_locked(locked),
    .chk_err_cnt(errc)
`endif
  );

  parallel_lfsr_gen #(
    .LFSR_W(16), .OUT_W(1), .POLY(16'hB400), .SEED(16'hACE1), .CNT_W(32)
  ) dut16 (
    .clk(clk), .reset(rst16), .enable(en16), .seed_load(ld16), .seed_in(seed16),
    .out_valid(vld16), .out_ready(rdy16), .out_data(dat16), .xfer_cnt(cnt16),
    .seed_zero(z16)
`ifdef PARALLEL_LFSR_CHK_EN
    , .chk_valid(1'b0), .chk_data(1'b0), .chk_locked(lk16), .chk_err_cnt(ec16)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the PRBS as a bit history. The first W bits of a stream are
  // the seed (MSB first); every later bit is the XOR of the history bits
  // selected by the tap mask.
  bit m_bits[$];
  int m_pos;

  task automatic m_reset(input logic [15:0] s, input int wd);
    m_bits.delete();
    m_pos = 0;
    for (int j = wd - 1; j >= 0; j--) m_bits.push_back(s[j]);
  endtask

  task automatic m_next(output logic [15:0] w, input int wd, input logic [15:0] poly, input int n);
    bit nb;
    while (m_bits.size() < m_pos + n) begin
      nb = 1'b0;
      for (int j = 0; j < wd; j++)
        if (poly[j]) nb ^= m_bits[m_bits.size() - 1 - j];
      m_bits.push_back(nb);
    end
    w = '0;
    for (int j = 0; j < n; j++) w = {w[14:0], m_bits[m_pos + j]};
    m_pos += n;
  endtask

  typedef struct {
    logic       r, e, y, l;
    logic [3:0] s;
    logic       v;
    logic [3:0] d;
    int         c;
    logic       z;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic y, input logic l,
                              input logic [3:0] s, input logic v, input logic [3:0] d,
                              input int c, input logic z);
    vec_t t;
    t.r = r; t.e = e; t.y = y; t.l = l; t.s = s;
    t.v = v; t.d = d; t.c = c; t.z = z;
    return t;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [15:0] exp;
    logic        hold;
    logic [3:0]  hold_d;
    logic [15:0] win, win16;
    int          nbits, first_rep, cyc, bad_bits;

    rst = 1'b1; en = 1'b0; rdy = 1'b0; ld = 1'b0; seed = '0;
    rst16 = 1'b1; en16 = 1'b0; rdy16 = 1'b0; ld16 = 1'b0; seed16 = '0;
`ifdef PARALLEL_LFSR_CHK_EN
    flip = '0;
`endif

    // inputs: r e y l seed | expected after the edge: v d cnt zero
    tbl.push_back(mk(1,0,0,0,4'h0, 0,4'h0,0,0));  // reset state
    tbl.push_back(mk(0,1,1,0,4'h0, 0,4'h0,0,0));  // PRIME
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'h1,0,0));  // first valid
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'h3,1,0));
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'h5,2,0));
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'hE,3,0));
    tbl.push_back(mk(0,0,1,0,4'h0, 0,4'h0,4,0));  // last word taken, stop
    tbl.push_back(mk(0,0,0,0,4'h0, 0,4'h0,4,0));
    tbl.push_back(mk(1,0,0,0,4'h0, 0,4'h0,0,0));  // reset
    tbl.push_back(mk(0,1,1,0,4'h0, 0,4'h0,0,0));
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'h1,0,0));
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'h3,1,0));
    tbl.push_back(mk(0,1,0,0,4'h0, 1,4'h3,1,0));  // stall x5
    tbl.push_back(mk(0,1,0,0,4'h0, 1,4'h3,1,0));
    tbl.push_back(mk(0,0,0,0,4'h0, 1,4'h3,1,0));  // enable drops: no retraction
    tbl.push_back(mk(0,0,0,0,4'h0, 1,4'h3,1,0));
    tbl.push_back(mk(0,0,0,0,4'h0, 1,4'h3,1,0));
    tbl.push_back(mk(0,0,1,0,4'h0, 0,4'h0,2,0));  // word completes, then idle
    tbl.push_back(mk(0,0,1,0,4'h0, 0,4'h0,2,0));
    tbl.push_back(mk(0,1,1,0,4'h0, 0,4'h0,2,0));  // re-enable -> PRIME
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'h5,2,0));  // continuation
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'hE,3,0));
    tbl.push_back(mk(0,1,0,0,4'h0, 1,4'hE,3,0));
    tbl.push_back(mk(0,1,0,1,4'h0, 0,4'h0,3,1));  // zero seed while stalled
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'h1,3,1));  // restart from SEED
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'h3,4,1));
    tbl.push_back(mk(0,1,1,1,4'h5, 0,4'h0,4,1));  // reseed beats handshake
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'h5,4,1));
    tbl.push_back(mk(0,1,1,0,4'h0, 1,4'hE,5,1));
    tbl.push_back(mk(1,1,1,0,4'h0, 0,4'h0,0,0));  // reset mid-transfer

    @(posedge clk); #1;
    rst16 = 1'b0; en16 = 1'b0;
    foreach (tbl[i]) begin
      rst = tbl[i].r; en = tbl[i].e; rdy = tbl[i].y; ld = tbl[i].l; seed = tbl[i].s;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), 32'(vld), 32'(tbl[i].v));
      if (tbl[i].v || tbl[i].r)
        check($sformatf("tbl%0d_data", i), 32'(dat), 32'(tbl[i].d));
      check($sformatf("tbl%0d_cnt", i), cnt, tbl[i].c);
      check($sformatf("tbl%0d_zero", i), 32'(zflag), 32'(tbl[i].z));
    end

    // Randomized traffic against the bit-stream model
    rst = 1'b1; en = 1'b0; rdy = 1'b0; ld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset(16'h1, 4);
    begin
      int  m_cnt;
      logic m_z;
      m_cnt = 0; m_z = 1'b0; hold = 1'b0; hold_d = '0;
      for (int k = 0; k < 3000; k++) begin
        check("rnd_cnt", cnt, m_cnt);
        check("rnd_zero", 32'(zflag), 32'(m_z));
        if (hold) begin
          check("rnd_hold_valid", 32'(vld), 32'd1);
          check("rnd_hold_data", 32'(dat), 32'(hold_d));
        end
        en   = ($urandom % 8) != 0;
        rdy  = ($urandom % 3) != 0;
        ld   = ($urandom % 64) == 0;
        seed = (($urandom % 4) == 0) ? 4'h0 : 4'($urandom);
        hold   = vld && !rdy && !ld;
        hold_d = dat;
        if (ld) begin
          m_reset((seed == 4'h0) ? 16'h1 : {12'h0, seed}, 4);
          if (seed == 4'h0) m_z = 1'b1;
        end else if (vld && rdy) begin
          m_next(exp, 4, 16'h000C, 4);
          check("rnd_word", 32'(dat), 32'(exp[3:0]));
          m_cnt++;
        end
        @(posedge clk); #1;
      end
    end
    en = 1'b0; rdy = 1'b0; ld = 1'b0;

    // Full period of the 16-bit default polynomial, one bit per transfer
    rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0; en16 = 1'b1; rdy16 = 1'b1;
    m_reset(16'hACE1, 16);
    nbits = 0; first_rep = 0; cyc = 0; bad_bits = 0; win = '0; win16 = '0;
    while (nbits < 65555 && cyc < 70000) begin
      @(posedge clk); #1;
      cyc++;
      if (vld16) begin
        nbits++;
        win = {win[14:0], dat16};
        m_next(exp, 16, 16'hB400, 1);
        if (dat16 !== exp[0]) bad_bits++;
        if (nbits == 16) win16 = win;
        if (nbits > 16 && win == 16'hACE1 && first_rep == 0) first_rep = nbits;
      end
    end
    check("prbs16_done", 32'(nbits), 32'd65555);
    check("prbs16_bits", bad_bits, 0);
    check("prbs16_seed_window", 32'(win16), 32'hACE1);
    check("prbs16_period", first_rep - 16, 65535);
    check("prbs16_cnt", cnt16, nbits - 1);
    en16 = 1'b0;

`ifdef PARALLEL_LFSR_CHK_EN
    // Checker: loop the 4-bit stream back with optional corruption
    rst = 1'b1; en = 1'b0; rdy = 1'b0; flip = '0;
    @(posedge clk); #1;
    check("chk_reset_locked", 32'(locked), 32'd0);
    check("chk_reset_err", 32'(errc), 32'd0);
    rst = 1'b0; en = 1'b1; rdy = 1'b1;
    cyc = 0;
    while (!vld && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("chk_first_valid", 32'(vld), 32'd1);
    @(posedge clk); #1;
    check("chk_lock_after_1", 32'(locked), 32'd1);
    flip = 4'h1;
    @(posedge clk); #1;
    flip = 4'h0;
    check("chk_single_err", 32'(errc), 32'd1);
    check("chk_single_locked", 32'(locked), 32'd1);
    @(posedge clk); #1;
    check("chk_clean_err", 32'(errc), 32'd1);
    flip = 4'h8;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("chk_7bad_locked", 32'(locked), 32'd1);
    check("chk_7bad_err", 32'(errc), 32'd8);
    @(posedge clk); #1;
    check("chk_8bad_locked", 32'(locked), 32'd0);
    check("chk_8bad_err", 32'(errc), 32'd9);
    flip = 4'h0;
    @(posedge clk); #1;
    check("chk_relock", 32'(locked), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("chk_relock_err", 32'(errc), 32'd9);
    check("chk_relock_held", 32'(locked), 32'd1);
    en = 1'b0; rdy = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parallel_lfsr_gen.md
Name: parallel_lfsr_gen

Overview:
- Parametrised parallel LFSR pattern generator; next generation of the 4-bit ready/data LFSR stream used for board bring-up and link tests.
- Emits OUT_W PRBS bits per accepted transfer on a valid/ready stream.
- Adds runtime seed load, enable/abort control and a transfer counter.
- Sits between the test-control CSRs and any sink under test (UART/GPIO/loopback path).

Parameters:
- LFSR_W, 16, LFSR state width (>=3).
- OUT_W, 4, bits emitted per transfer (1..LFSR_W).
- POLY, 16'hB400, Fibonacci tap mask; bit i set means state[i] feeds the XOR.
- SEED, 16'hACE1, reset seed, also substituted for an all-zero seed.
- CNT_W, 32, transfer counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request
- seed_load  in  1  one-cycle pulse: load seed_in
- seed_in  in  LFSR_W  runtime seed
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts
- out_data  out  OUT_W  PRBS word, MSB = oldest bit
- xfer_cnt  out  CNT_W  accepted transfers, wraps
- seed_zero  out  1  sticky: an all-zero seed was replaced with SEED

Behaviour:
- One clock (clk); reset is synchronous and active-high. On reset: state=SEED, FSM=IDLE, out_valid=0, out_data=0, xfer_cnt=0, seed_zero=0.
- Step function, for one bit:
  - out bit = state[LFSR_W-1];
  - fb = ^(state & POLY);
  - state <= {state[LFSR_W-2:0], fb}.
  - A word applies OUT_W steps combinationally. The first bit produced lands in out_data[OUT_W-1].
- FSM IDLE: out_valid=0. If enable=1, go to PRIME.
- FSM PRIME (exactly 1 cycle):
  - out_data <= word(state); state <= advanced by OUT_W steps.
  - out_valid <= 1; go to RUN.
  - First valid therefore appears 2 cycles after enable rises.
- FSM RUN: out_valid=1.
  - out_data/out_valid stay stable until a handshake (valid&&ready).
  - On a handshake with enable=1: next word and state load in the same cycle, out_valid stays 1, giving one word per cycle back-to-back.
  - On a handshake with enable=0: out_valid <= 0, go to IDLE. The precomputed state is kept, so a re-enable continues the sequence without a gap.
  - enable=0 without a handshake: hold valid (no retraction).
- xfer_cnt increments on every handshake and wraps at 2^CNT_W.
- seed_load (any state) has priority over everything:
  - state <= (seed_in==0) ? SEED : seed_in; seed_zero set if seed_in==0.
  - out_valid <= 0; a pending word is discarded (the only legal valid retraction).
  - Go to PRIME if enable=1, else IDLE.
  - A handshake in the same cycle is not counted.
- reset mid-transfer: all state returns to reset values next cycle; seed_zero cleared.

Optional Feature:
- Macro PARALLEL_LFSR_CHK_EN.
- When defined, adds a self-synchronising checker:
  - Inputs chk_valid (1), chk_data (OUT_W).
  - Outputs chk_locked (1), chk_err_cnt (16).
- Checker states: SYNC and LOCK.
  - SYNC: shift received bits into a local state until ceil(LFSR_W/OUT_W) words have been absorbed, then go to LOCK.
  - LOCK: predict each word with the same step function. On a mismatch, increment chk_err_cnt (saturates at 16'hFFFF). After 8 consecutive mismatching words, drop chk_locked and return to SYNC.
- Reset clears the checker state, chk_locked and chk_err_cnt.
- When the macro is undefined, these ports and the logic are absent and the generator behaves identically.

Decomposition:
- Package parallel_lfsr_pkg contains:
  - FSM enum (IDLE, PRIME, RUN) and checker enum (SYNC, LOCK);
  - function lfsr_advance(state, poly, n) returning the next state and the n-bit word;
  - checker mismatch-limit constant (8).
- Sub-module parallel_lfsr_chk for the checker, instantiated under the macro.

Test Plan (LFSR_W=4, OUT_W=4, POLY=4'hC, SEED=4'h1 unless stated):
- Reset, enable=1, out_ready=1 -> first valid on cycle 2 after enable; words 4'h1, 4'h3, 4'h5, 4'hE on consecutive cycles; xfer_cnt 1..4.
- Same run with out_ready held 0 for 5 cycles at word 2 -> out_data stays 4'h3 with valid=1; no count change; sequence resumes 4'h5.
- enable dropped during stall -> word completes on ready, then valid=0; re-enable -> next word is the continuation (4'h5), not a restart.
- seed_load with seed_in=0 while valid and not ready -> valid drops next cycle, seed_zero=1, restart from 4'h1 after PRIME.
- OUT_W=1, 16-bit defaults, 65535 transfers -> sequence period is exactly 65535 and state returns to 16'hACE1.
- CHK_EN: loop out_data to chk_data -> chk_locked after 1 word; flip one bit -> chk_err_cnt=1, lock held; 8 corrupted words -> unlock, resync, relock.
